// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. One operand bit pair is combined per clock,
//   LSB first, through a full-adder cell (the half-adder cell extended with a
//   carry-in). A start/busy/done handshake frames each operation.
//
//   Subtraction is done as A + ~B + 1, so for subtraction C is the
//   "not-borrow" flag (1 when A >= B).
//
// Parameters
//   WIDTH   operand/result width in bits (>= 1)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset (overrides start)
//   start   request; sampled only when ready (idle or done cycle)
//   op_sub  0: A+B+CIN, 1: A-B (CIN ignored); sampled with start
//   A, B    operands; sampled with start
//   CIN     carry-in for add; sampled with start
//   busy    high while bits are being processed (exactly WIDTH cycles)
//   done    one-cycle pulse; S/C are valid from this cycle on
//   S       result modulo 2^WIDTH, held until the next completed operation
//   C       carry-out (add) / not-borrow (sub), held with S
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C
);

   // A 1-bit counter is kept even for WIDTH=1 so the vector is never empty.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Sum output of the full-adder cell.
   function automatic logic fa_sum(input logic x, input logic y, input logic z);
      fa_sum = x ^ y ^ z;
   endfunction

   // Carry output of the full-adder cell (majority of the three inputs).
   function automatic logic fa_carry(input logic x, input logic y, input logic z);
      fa_carry = (x & y) | (x & z) | (y & z);
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic             accept_s;
   logic             last_bit_s;

   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] res_r;

   logic             sum_bit_s;
   logic             carry_next_s;
   logic [WIDTH-1:0] res_next_s;

   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] s_r;
   logic             c_r;

   assign busy = busy_r;
   assign done = done_r;
   assign S    = s_r;
   assign C    = c_r;

   // Last bit is being processed when the counter reaches WIDTH-1 in RUN.
   assign last_bit_s = (state_r == ST_RUN) && (cnt_r == CNT_LAST);

   // Next-state logic and accept decode; start is only honoured when ready.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s = ST_RUN;
               accept_s     = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_bit_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            // Back-to-back accept: a start in the done cycle goes straight to RUN.
            if (start) begin
               next_state_s = ST_RUN;
               accept_s     = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
            accept_s     = 1'b0;
         end
      endcase
   end

   // One full-adder step on the current LSBs; the new sum bit enters the
   // result at the MSB so that after WIDTH steps the result is aligned.
   always_comb begin
      sum_bit_s                = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
      carry_next_s             = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
      res_next_s               = res_r >> 1'b1;
      res_next_s[WIDTH-1]      = sum_bit_s;
   end

   // State register plus registered busy/done flags derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == ST_RUN);
         done_r  <= (next_state_s == ST_DONE);
      end
   end

   // Operand shift registers, carry, bit counter and partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r  <= '0;
         b_sh_r  <= '0;
         carry_r <= 1'b0;
         cnt_r   <= CNT_ZERO;
         res_r   <= '0;
      end else if (accept_s) begin
         // Subtraction is A + ~B + 1: invert B and force the initial carry.
         a_sh_r  <= A;
         b_sh_r  <= op_sub ? ~B : B;
         carry_r <= op_sub ? 1'b1 : CIN;
         cnt_r   <= CNT_ZERO;
         res_r   <= '0;
      end else if (state_r == ST_RUN) begin
         a_sh_r  <= a_sh_r >> 1'b1;
         b_sh_r  <= b_sh_r >> 1'b1;
         carry_r <= carry_next_s;
         cnt_r   <= cnt_r + CNT_ONE;
         res_r   <= res_next_s;
      end else begin
         a_sh_r  <= a_sh_r;
         b_sh_r  <= b_sh_r;
         carry_r <= carry_r;
         cnt_r   <= cnt_r;
         res_r   <= res_r;
      end
   end

   // Visible result: updated only on the final bit, so partial sums never
   // appear on S/C while RUN is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_r <= '0;
         c_r <= 1'b0;
      end else if (last_bit_s) begin
         s_r <= res_next_s;
         c_r <= carry_next_s;
      end else begin
         s_r <= s_r;
         c_r <= c_r;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       op_sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] s;
   logic       c;

   // WIDTH=1 instance, sharing clock and reset
   logic       start1;
   logic       op_sub1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] s1;
   logic       c1;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .A(a), .B(b), .CIN(cin),
      .busy(busy), .done(done), .S(s), .C(c)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .A(a1), .B(b1), .CIN(cin1),
      .busy(busy1), .done(done1), .S(s1), .C(c1)
   );

   // Reference: {C,S} from plain arithmetic.
   function automatic logic [8:0] model(input logic sub, input logic [7:0] x,
                                        input logic [7:0] y, input logic ci);
      logic [7:0] diff;
      if (sub) begin
         diff  = x - y;
         model = {(x >= y), diff};
      end else begin
         model = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      end
   endfunction

   // Present a request for one cycle, then scramble inputs.
   task automatic drive_start(input logic sub, input logic [7:0] ia, input logic [7:0] ib,
                              input logic icin);
      @(negedge clk);
      start = 1'b1; op_sub = sub; a = ia; b = ib; cin = icin;
      @(posedge clk);
      #1;
      start = 1'b0; op_sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom);
   endtask

   // Wait (bounded) for done; report latency in negedges and busy cycles.
   task automatic wait_done(output logic [7:0] os, output logic oc, output int lat,
                            output int bcnt);
      lat = -1; bcnt = 0; os = 8'h00; oc = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busy === 1'b1) bcnt++;
         if (done === 1'b1) begin
            lat = k; os = s; oc = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; op_sub = 1'b0; a = 8'h5A; b = 8'h3C; cin = 1'b1;
      start1 = 1'b0; op_sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else passes++;
      checks++; if (s !== 8'h00) $display("FAIL reset_s: got %h exp 00", s); else passes++;
      checks++; if (c !== 1'b0) $display("FAIL reset_c: got %b exp 0", c); else passes++;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_no_accept: busy got %b exp 0", busy); else passes++;
   endtask

   task automatic test_add;
      logic [7:0] os; logic oc; int lat; int bcnt;
      drive_start(1'b0, 8'h0F, 8'h01, 1'b0);
      wait_done(os, oc, lat, bcnt);
      checks++; if (os !== 8'h10) $display("FAIL add_s: got %h exp 10", os); else passes++;
      checks++; if (oc !== 1'b0) $display("FAIL add_c: got %b exp 0", oc); else passes++;
      checks++; if (lat !== 9) $display("FAIL add_latency: got %0d exp 9", lat); else passes++;
      checks++; if (bcnt !== 8) $display("FAIL add_busy_cycles: got %0d exp 8", bcnt); else passes++;
   endtask

   task automatic test_wrap;
      logic [7:0] os; logic oc; int lat; int bcnt;
      drive_start(1'b0, 8'hFF, 8'h01, 1'b0);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== 9'h100) $display("FAIL wrap1: got C=%b S=%h exp C=1 S=00", oc, os); else passes++;
      drive_start(1'b0, 8'hFF, 8'hFF, 1'b1);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== 9'h1FF) $display("FAIL wrap2: got C=%b S=%h exp C=1 S=FF", oc, os); else passes++;
   endtask

   task automatic test_sub;
      logic [7:0] os; logic oc; int lat; int bcnt;
      drive_start(1'b1, 8'h07, 8'h05, 1'b0);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== 9'h102) $display("FAIL sub1: got C=%b S=%h exp C=1 S=02", oc, os); else passes++;
      drive_start(1'b1, 8'h05, 8'h07, 1'b1);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== 9'h0FE) $display("FAIL sub2: got C=%b S=%h exp C=0 S=FE", oc, os); else passes++;
   endtask

   task automatic test_random;
      logic [7:0] os; logic oc; int lat; int bcnt;
      logic sub; logic [7:0] x; logic [7:0] y; logic ci; logic [8:0] exp_v;
      for (int n = 0; n < 30; n++) begin
         sub = 1'($urandom); x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
         if (n == 0) begin x = 8'h00; y = 8'h00; sub = 1'b1; end
         exp_v = model(sub, x, y, ci);
         drive_start(sub, x, y, ci);
         wait_done(os, oc, lat, bcnt);
         checks++;
         if ({oc, os} !== exp_v || lat !== 9)
            $display("FAIL random_%0d: sub=%b A=%h B=%h CIN=%b got C=%b S=%h lat=%0d exp C=%b S=%h lat=9",
                     n, sub, x, y, ci, oc, os, lat, exp_v[8], exp_v[7:0], lat);
         else passes++;
      end
   endtask

   task automatic test_hold;
      logic [7:0] os; logic oc; int lat; int bcnt; logic [8:0] exp_v;
      int bad;
      exp_v = model(1'b0, 8'hA5, 8'h3C, 1'b1);
      drive_start(1'b0, 8'hA5, 8'h3C, 1'b1);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== exp_v) $display("FAIL hold_result: got %h exp %h", {oc, os}, exp_v); else passes++;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || {c, s} !== exp_v) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL hold_after_done: got %0d bad cycles exp 0", bad); else passes++;
   endtask

   task automatic test_ignore_start;
      logic [7:0] os; logic oc; int lat; int bcnt; logic [8:0] prev; logic [8:0] exp_v;
      int bad;
      prev  = {c, s};
      exp_v = model(1'b0, 8'h0F, 8'h01, 1'b0);
      drive_start(1'b0, 8'h0F, 8'h01, 1'b0);
      bad = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if ({c, s} !== prev || busy !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL run_outputs_held: got %0d bad cycles exp 0", bad); else passes++;
      start = 1'b1; op_sub = 1'b1; a = 8'h33; b = 8'h99; cin = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== exp_v) $display("FAIL ignore_start_result: got %h exp %h", {oc, os}, exp_v); else passes++;
      checks++; if (lat !== 6) $display("FAIL ignore_start_latency: got %0d exp 6", lat); else passes++;
   endtask

   task automatic test_back_to_back;
      logic [7:0] os; logic oc; int lat; int bcnt; logic [8:0] exp_v;
      drive_start(1'b0, 8'h12, 8'h34, 1'b0);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== 9'h046) $display("FAIL b2b_first: got %h exp 046", {oc, os}); else passes++;
      // Still in the done cycle: request the next op immediately.
      exp_v = model(1'b1, 8'h10, 8'h20, 1'b0);
      start = 1'b1; op_sub = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== exp_v) $display("FAIL b2b_second: got %h exp %h", {oc, os}, exp_v); else passes++;
      checks++; if (lat !== 9 || bcnt !== 8) $display("FAIL b2b_no_gap: got lat=%0d busy=%0d exp lat=9 busy=8", lat, bcnt); else passes++;
   endtask

   task automatic test_abort;
      logic [7:0] os; logic oc; int lat; int bcnt; int dones;
      drive_start(1'b0, 8'h77, 8'h11, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || c !== 1'b0)
         $display("FAIL abort_clear: got busy=%b done=%b S=%h C=%b exp 0 0 00 0", busy, done, s, c);
      else passes++;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d pulses exp 0", dones); else passes++;
      drive_start(1'b0, 8'h80, 8'h80, 1'b1);
      wait_done(os, oc, lat, bcnt);
      checks++; if ({oc, os} !== 9'h101 || lat !== 9) $display("FAIL abort_next_op: got %h lat=%0d exp 101 lat=9", {oc, os}, lat); else passes++;
   endtask

   task automatic test_width1;
      logic sub; logic x; logic y; logic ci; logic [1:0] exp_v; logic [0:0] d;
      int lat; int bcnt; logic [1:0] got;
      for (int i = 0; i < 16; i++) begin
         sub = i[3]; x = i[2]; y = i[1]; ci = i[0];
         if (sub) begin
            d     = x - y;
            exp_v = {(x >= y), d};
         end else begin
            exp_v = {1'b0, x} + {1'b0, y} + {1'b0, ci};
         end
         @(negedge clk);
         start1 = 1'b1; op_sub1 = sub; a1 = x; b1 = y; cin1 = ci;
         @(posedge clk);
         #1;
         start1 = 1'b0; a1 = ~x; b1 = ~y; cin1 = ~ci;
         lat = -1; bcnt = 0; got = 2'b00;
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy1 === 1'b1) bcnt++;
            if (done1 === 1'b1) begin
               lat = k; got = {c1, s1};
               break;
            end
         end
         checks++;
         if (got !== exp_v || lat !== 2 || bcnt !== 1)
            $display("FAIL width1_%0d: sub=%b a=%b b=%b cin=%b got C,S=%b lat=%0d busy=%0d exp %b lat=2 busy=1",
                     i, sub, x, y, ci, got, lat, bcnt, exp_v);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_wrap();
      test_sub();
      test_random();
      test_hold();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      test_width1();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
